// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse key decoder.
// Character codes, FSM states and pattern widths.
package morse_pkg;

   localparam int PAT_W  = 5;
   localparam int LEN_W  = 3;
   localparam int CODE_W = 6;

   localparam logic [LEN_W-1:0] MAX_ELEMS = 3'd5;

   localparam logic [CODE_W-1:0] CODE_A       = 6'd0;
   localparam logic [CODE_W-1:0] CODE_ZERO    = 6'd26;
   localparam logic [CODE_W-1:0] CODE_SPACE   = 6'd36;
   localparam logic [CODE_W-1:0] CODE_INVALID = 6'd63;

   typedef enum logic [1:0] {
      IDLE,
      PRESS,
      GAP
   } state_e;

endpackage

// File: rtl/morse_lut.sv
// Morse pattern to character code lookup.
// First element sits at bit len-1, latest at bit 0.
module morse_lut
   import morse_pkg::*;
(
   input  logic [PAT_W-1:0]  pattern_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic [CODE_W-1:0] code_o
);

   logic [PAT_W-1:0] mask;
   logic [PAT_W-1:0] pm;
   logic [7:0]       key;

   // Keep only the valid elements, then match length and pattern together
   always_comb begin
      mask   = (5'd1 << len_i) - 5'd1;
      pm     = pattern_i & mask;
      key    = {len_i, pm};
      code_o = CODE_INVALID;
      if (len_i <= MAX_ELEMS) begin
         case (key)
            8'b010_00001: code_o = CODE_A + 6'd0;
            8'b100_01000: code_o = CODE_A + 6'd1;
            8'b100_01010: code_o = CODE_A + 6'd2;
            8'b011_00100: code_o = CODE_A + 6'd3;
            8'b001_00000: code_o = CODE_A + 6'd4;
            8'b100_00010: code_o = CODE_A + 6'd5;
            8'b011_00110: code_o = CODE_A + 6'd6;
            8'b100_00000: code_o = CODE_A + 6'd7;
            8'b010_00000: code_o = CODE_A + 6'd8;
            8'b100_00111: code_o = CODE_A + 6'd9;
            8'b011_00101: code_o = CODE_A + 6'd10;
            8'b100_00100: code_o = CODE_A + 6'd11;
            8'b010_00011: code_o = CODE_A + 6'd12;
            8'b010_00010: code_o = CODE_A + 6'd13;
            8'b011_00111: code_o = CODE_A + 6'd14;
            8'b100_00110: code_o = CODE_A + 6'd15;
            8'b100_01101: code_o = CODE_A + 6'd16;
            8'b011_00010: code_o = CODE_A + 6'd17;
            8'b011_00000: code_o = CODE_A + 6'd18;
            8'b001_00001: code_o = CODE_A + 6'd19;
            8'b011_00001: code_o = CODE_A + 6'd20;
            8'b100_00001: code_o = CODE_A + 6'd21;
            8'b011_00011: code_o = CODE_A + 6'd22;
            8'b100_01001: code_o = CODE_A + 6'd23;
            8'b100_01011: code_o = CODE_A + 6'd24;
            8'b100_01100: code_o = CODE_A + 6'd25;
            8'b101_11111: code_o = CODE_ZERO + 6'd0;
            8'b101_01111: code_o = CODE_ZERO + 6'd1;
            8'b101_00111: code_o = CODE_ZERO + 6'd2;
            8'b101_00011: code_o = CODE_ZERO + 6'd3;
            8'b101_00001: code_o = CODE_ZERO + 6'd4;
            8'b101_00000: code_o = CODE_ZERO + 6'd5;
            8'b101_10000: code_o = CODE_ZERO + 6'd6;
            8'b101_11000: code_o = CODE_ZERO + 6'd7;
            8'b101_11100: code_o = CODE_ZERO + 6'd8;
            8'b101_11110: code_o = CODE_ZERO + 6'd9;
            default:      code_o = CODE_INVALID;
         endcase
      end
   end

endmodule

// File: rtl/morse_key_decoder.sv
// Morse key to letterNum/send stream producer.
// Sync + debounce, dot/dash timing, letter and word gaps.
module morse_key_decoder
   import morse_pkg::*;
#(
   parameter int CNT_W            = 16,
   parameter int DEB_TICKS        = 20,
   parameter int DASH_TICKS       = 200,
   parameter int LETTER_GAP_TICKS = 600,
   parameter int WORD_GAP_TICKS   = 1400
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick,
   input  logic              key,
   output logic [CODE_W-1:0] letterNum,
   output logic              send,
   output logic              key_db,
   output logic [LEN_W-1:0]  elem_cnt,
   output logic              overflow
);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_TICKS - 1);
   localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(DASH_TICKS);
   localparam logic [CNT_W-1:0] LGAP_C   = CNT_W'(LETTER_GAP_TICKS);
   localparam logic [CNT_W-1:0] WGAP_C   = CNT_W'(WORD_GAP_TICKS);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic              sync1_q, sync2_q, kdly_q;
   logic              key_db_q, key_db_d;
   logic [CNT_W-1:0]  deb_q, deb_d;
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  dur_q, dur_d, gap_q, gap_d;
   logic [CNT_W-1:0]  dur_inc, gap_inc;
   logic [PAT_W-1:0]  pat_q, pat_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              ovf_q, ovf_d;
   logic              ws_q, ws_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              send_q, send_d;
   logic [CODE_W-1:0] lut_code;
   logic              rise, fall;

   morse_lut u_lut (
      .pattern_i (pat_q),
      .len_i     (len_q),
      .code_o    (lut_code)
   );

   assign rise = key_db_q & ~kdly_q;
   assign fall = ~key_db_q & kdly_q;

   // Debounce: toggle only after DEB_TICKS consecutive mismatching ticks
   always_comb begin
      deb_d    = deb_q;
      key_db_d = key_db_q;
      if (sync2_q == key_db_q) begin
         deb_d = '0;
      end else if (tick) begin
         if (deb_q >= DEB_LAST) begin
            key_db_d = ~key_db_q;
            deb_d    = '0;
         end else begin
            deb_d = deb_q + 1'b1;
         end
      end
   end

   // Element timing, letter/word gap detection and output codes
   always_comb begin
      state_d = state_q;
      dur_d   = dur_q;
      gap_d   = gap_q;
      pat_d   = pat_q;
      len_d   = len_q;
      ovf_d   = ovf_q;
      ws_d    = ws_q;
      code_d  = code_q;
      send_d  = 1'b0;
      dur_inc = tick ? sat_inc(dur_q) : dur_q;
      gap_inc = tick ? sat_inc(gap_q) : gap_q;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = PRESS;
               dur_d   = '0;
               ws_d    = 1'b1;
            end else if (!ws_q) begin
               gap_d = gap_inc;
               if (gap_inc >= WGAP_C && !send_q) begin
                  code_d = CODE_SPACE;
                  send_d = 1'b1;
                  ws_d   = 1'b1;
               end
            end
         end
         PRESS: begin
            if (fall) begin
               if (len_q < MAX_ELEMS) begin
                  pat_d = {pat_q[PAT_W-2:0], (dur_q >= DASH_C)};
                  len_d = len_q + 3'd1;
               end else begin
                  ovf_d = 1'b1;
               end
               gap_d   = '0;
               state_d = GAP;
            end else begin
               dur_d = dur_inc;
            end
         end
         GAP: begin
            if (rise) begin
               state_d = PRESS;
               dur_d   = '0;
            end else begin
               gap_d = gap_inc;
               if (gap_inc >= LGAP_C) begin
                  code_d  = ovf_q ? CODE_INVALID : lut_code;
                  send_d  = 1'b1;
                  pat_d   = '0;
                  len_d   = '0;
                  ovf_d   = 1'b0;
                  ws_d    = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         kdly_q   <= 1'b0;
         key_db_q <= 1'b0;
         deb_q    <= '0;
         state_q  <= IDLE;
         dur_q    <= '0;
         gap_q    <= '0;
         pat_q    <= '0;
         len_q    <= '0;
         ovf_q    <= 1'b0;
         ws_q     <= 1'b1;
         code_q   <= '0;
         send_q   <= 1'b0;
      end else begin
         sync1_q  <= key;
         sync2_q  <= sync1_q;
         kdly_q   <= key_db_q;
         key_db_q <= key_db_d;
         deb_q    <= deb_d;
         state_q  <= state_d;
         dur_q    <= dur_d;
         gap_q    <= gap_d;
         pat_q    <= pat_d;
         len_q    <= len_d;
         ovf_q    <= ovf_d;
         ws_q     <= ws_d;
         code_q   <= code_d;
         send_q   <= send_d;
      end
   end

   assign letterNum = code_q;
   assign send      = send_q;
   assign key_db    = key_db_q;
   assign elem_cnt  = len_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_morse_key_decoder.sv
// Randomised + directed bench for morse_key_decoder.
// Reference model works on Morse strings and tick timestamps.
module tb_morse_key_decoder;

   logic       clk = 1'b0;
   logic       reset, tick, key;
   logic [5:0] letterNum;
   logic       send, key_db, overflow;
   logic [2:0] elem_cnt;

   morse_key_decoder dut (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .key       (key),
      .letterNum (letterNum),
      .send      (send),
      .key_db    (key_db),
      .elem_cnt  (elem_cnt),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int t;
      int c;
   } ev_t;

   ev_t   obs[$];
   ev_t   expq[$];
   int    errors = 0;
   int    checks = 0;
   int    tcnt = 0;
   int    last_fall = 0;
   string cur = "";
   logic  prev_send = 1'b0;

   string morse [36] = '{
      ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
      "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
      "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
      "-.--", "--..", "-----", ".----", "..---", "...--",
      "....-", ".....", "-....", "--...", "---..", "----."
   };

   task automatic chk(input string tag, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
      end
   endtask

   function automatic int code_of(input string s);
      if (s.len() == 0 || s.len() > 5) return 63;
      for (int i = 0; i < 36; i++)
         if (morse[i] == s) return i;
      return 63;
   endfunction

   always @(posedge clk) begin
      #1;
      if (send) begin
         chk("send_b2b", int'(prev_send), 0);
         obs.push_back('{tcnt, int'(letterNum)});
      end
      prev_send = send;
   end

   task automatic step_tick();
      @(negedge clk);
      @(negedge clk);
      tick = 1'b1;
      tcnt++;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step_tick();
   endtask

   task automatic press(input int n);
      key = 1'b1;
      idle(n);
      key = 1'b0;
      last_fall = tcnt;
      cur = {cur, (n >= 200) ? "-" : "."};
   endtask

   task automatic model_gap(input int g);
      if (cur.len() > 0 && g >= 600) begin
         expq.push_back('{last_fall + 620, code_of(cur)});
         cur = "";
         if (g >= 1400)
            expq.push_back('{last_fall + 1420, 36});
      end
   endtask

   task automatic gap(input int g);
      model_gap(g);
      idle(g);
   endtask

   task automatic compare_sends(input string tag);
      int n;
      chk({tag, "_count"}, obs.size(), expq.size());
      n = (obs.size() < expq.size()) ? obs.size() : expq.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_code"}, obs[i].c, expq[i].c);
         chk({tag, "_tick"}, obs[i].t, expq[i].t);
      end
      obs.delete();
      expq.delete();
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_letter"}, int'(letterNum), 0);
      chk({tag, "_send"}, int'(send), 0);
      chk({tag, "_keydb"}, int'(key_db), 0);
      chk({tag, "_elem"}, int'(elem_cnt), 0);
      chk({tag, "_ovf"}, int'(overflow), 0);
   endtask

   initial begin
      int    idx, ne;
      string s;
      reset = 1'b1;
      tick  = 1'b0;
      key   = 1'b0;
      repeat (3) @(negedge clk);
      chk_idle_outs("rst");
      reset = 1'b0;
      idle(30);

      // A
      press(50); gap(100); press(300);
      model_gap(700);
      idle(300);
      chk("A_elem_pre", int'(elem_cnt), 2);
      idle(400);
      chk("A_elem_post", int'(elem_cnt), 0);
      compare_sends("A");

      // B then space, nothing more
      press(300); gap(100); press(50); gap(100);
      press(50); gap(100); press(50); gap(1600);
      idle(500);
      compare_sends("B_space");

      // 5
      for (int i = 0; i < 5; i++) begin
         press(50);
         if (i < 4) gap(100);
      end
      gap(700);
      compare_sends("five");

      // six dots -> overflow
      for (int i = 0; i < 6; i++) begin
         press(50);
         if (i < 5) gap(100);
      end
      model_gap(700);
      idle(50);
      chk("ovf_set", int'(overflow), 1);
      chk("ovf_elem", int'(elem_cnt), 5);
      idle(650);
      chk("ovf_clr", int'(overflow), 0);
      compare_sends("six");

      // glitch in idle
      key = 1'b1;
      idle(10);
      chk("glitch_kdb_hi", int'(key_db), 0);
      key = 1'b0;
      idle(100);
      chk("glitch_kdb", int'(key_db), 0);
      chk("glitch_elem", int'(elem_cnt), 0);
      compare_sends("glitch");

      // letter gap boundary 599 / 600
      press(50); gap(599); press(50);
      model_gap(700);
      idle(100);
      chk("g599_elem", int'(elem_cnt), 2);
      idle(600);
      press(50); gap(600);
      press(50); gap(700);
      compare_sends("gapbnd");
      chk("hold_letter", int'(letterNum), 4);

      // reset mid dash
      key = 1'b1;
      idle(150);
      chk("mid_kdb", int'(key_db), 1);
      reset = 1'b1;
      @(negedge clk);
      chk_idle_outs("midrst");
      key = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      idle(2000);
      chk_idle_outs("postrst");
      compare_sends("rst_nosend");

      // random letters
      for (int l = 0; l < 4; l++) begin
         idx = $urandom_range(0, 35);
         s = morse[idx];
         if ($urandom_range(0, 5) == 0) begin
            s = "";
            for (int i = 0; i < 6; i++)
               if ($urandom_range(0, 1) == 1) s = {s, "-"};
               else s = {s, "."};
         end
         ne = s.len();
         for (int i = 0; i < ne; i++) begin
            if (s[i] == "-") press($urandom_range(220, 380));
            else press($urandom_range(30, 150));
            if (i < ne - 1) gap($urandom_range(40, 560));
         end
         if ($urandom_range(0, 3) == 0) gap(1450);
         else gap($urandom_range(620, 900));
         compare_sends("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/morse_key_decoder.md
Name: morse_key_decoder

Overview:
- Converts a single Morse key (push-button) into the `letterNum`/`send` stream consumed by the on-screen text renderer. It is the producer end of that interface.
- Synchronises and debounces the key, then times each press as dot or dash.
- Accumulates up to 5 elements and, after an inter-letter gap, emits one 6-bit character code with a one-cycle send strobe.
- Also emits a space code after a word gap. Sits between the board button and the VGA text path.

Parameters:
- CNT_W, 16, width of the press and gap duration counters (saturating).
- DEB_TICKS, 20, ticks the synchronised key must be stable before the debounced level changes.
- DASH_TICKS, 200, press duration in ticks at or above which an element is a dash; below it is a dot.
- LETTER_GAP_TICKS, 600, release duration in ticks that closes the current letter.
- WORD_GAP_TICKS, 1400, release duration in ticks (measured from release) that emits one space code.

Ports:
- clk  in  1  system clock (all state on posedge clk).
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  1 ms timebase enable, one clk wide; all duration counting advances only on tick.
- key  in  1  raw button, asynchronous to clk, 1 = pressed.
- letterNum  out  6  character code, held stable from the send cycle until the next send.
- send  out  1  one-clk strobe; letterNum is valid in the same cycle.
- key_db  out  1  debounced key level (drives an LED).
- elem_cnt  out  3  number of elements accumulated in the current letter (0..5).
- overflow  out  1  high while the current letter has exceeded 5 elements.

Behaviour:
- Reset values: letterNum=0, send=0, key_db=0, elem_cnt=0, overflow=0. Sync flops=0. Counters=0. State=IDLE. ws_done=1 (no space is emitted after reset).
- Key synchroniser: 2-flop synchroniser on `key`.
  - Debounce counter counts ticks while the synchronised level differs from key_db; it clears when they match.
  - key_db toggles on the tick where the count reaches DEB_TICKS.
  - A glitch shorter than DEB_TICKS never changes key_db.
- Character code map:
  - A..Z = 0..25.
  - '0'..'9' = 26..35.
  - space = 36.
  - Invalid or unmapped pattern = 63.
- Pattern register: 5 bits. Each new element shifts in at the LSB (1 = dash, 0 = dot). elem_cnt gives the valid length.
- FSM states: IDLE, PRESS, GAP.
- IDLE:
  - On key_db rise → PRESS; duration counter cleared.
  - While in IDLE with ws_done=0, the gap counter keeps running. When it reaches WORD_GAP_TICKS: letterNum=36, send=1 for one clk, ws_done=1.
- PRESS:
  - Duration counter increments on tick, saturating at 2^CNT_W−1.
  - On key_db fall, the element is classified in that same clk: dash if duration ≥ DASH_TICKS, else dot.
  - If elem_cnt<5: shift the element in and increment elem_cnt. Otherwise set overflow=1 and leave the pattern and elem_cnt unchanged.
  - Gap counter cleared → GAP.
- GAP:
  - Gap counter increments on tick, saturating.
  - key_db rise before LETTER_GAP_TICKS → PRESS (same letter continues).
  - Gap counter reaching LETTER_GAP_TICKS:
    - letterNum = lut(pattern, elem_cnt), or 63 if overflow.
    - send=1 for exactly one clk.
    - Pattern, elem_cnt and overflow cleared; ws_done=0.
    - → IDLE with the gap counter not cleared, so the word gap is measured from release.
- Key press in IDLE after a letter: ws_done=1, no space is emitted.
- send is never asserted on two consecutive clks.
- A tick coincident with a key_db edge: the edge transition wins; the counter cleared on entry does not also increment.
- reset mid-press or mid-gap: everything returns to reset values immediately. No send is produced for the partial letter.

Decomposition:
- Package morse_pkg holds:
  - Character code constants (CODE_A=0, CODE_ZERO=26, CODE_SPACE=36, CODE_INVALID=63).
  - The state enum (IDLE, PRESS, GAP).
  - The 5-bit pattern and 3-bit length widths.
- Sub-module morse_lut: purely combinational (pattern[4:0], len[2:0]) → code[5:0].
  - Covers all 26 letters and 10 digits.
  - Returns 63 for len=0 or any unmapped pattern.
  - Tested standalone exhaustively over 6*32 inputs.

Test Plan:
- Press 50 ticks, release 100, press 300, release 700 → one send with letterNum=0 ('A'). elem_cnt is 2 before the send and 0 after.
- Dash, dot, dot, dot (300/50/50/50 ticks, 100-tick gaps, then 700 gap) → letterNum=1 ('B'). Then idle to 1400 ticks after release → second send with letterNum=36. Idle further → no third send.
- Five dots then letter gap → letterNum=31 ('5'). Six dots → overflow=1 after the 6th, then send with letterNum=63.
- key glitch high for 10 ticks (< DEB_TICKS) in IDLE → key_db stays 0, no state change, no send.
- reset asserted 150 ticks into a dash press, released, idle 2000 ticks → all outputs 0, no send at all.
- Dot, then a second press at gap 599 ticks → same letter continues (elem_cnt=2). A gap of exactly 600 ticks closes the letter on that tick.
